// File: rtl/sub3_pipe.sv
// sub3_pipe: two-stage pipelined three-operand subtractor, diff = a - b - c - bin.
// Stage 1 folds the operand inversions and the +2-bin constant into a carry-save
// pair; stage 2 resolves the pair with a Kogge-Stone prefix adder and registers
// the result. Valid/ready handshakes on both ends, no bubbles.
// Optional build macro SUB3_SAT_EN: clamp negative results to zero (neg still
// reports the true sign).
module sub3_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] diff,
    output logic             neg
);

    localparam int W2 = WIDTH + 2;

    logic [W2-1:0] s1_sum;
    logic [W2-1:0] s1_carry;
    logic          s1_cin;
    logic          s1_valid;

    logic          s2_free;
    logic          s1_adv;
    logic          accept;

    logic [W2-1:0] csa_sum;
    logic [W2-1:0] csa_carry;
    logic [W2-1:0] res;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    // Carry-save compression of a + ~b + ~c. The shifted-out carry LSB is a free
    // slot that carries +1 of the constant; the remaining +(1-bin) rides in as
    // the prefix adder's carry-in, so no fourth operand is needed.
    always_comb begin
        logic [W2-1:0] op_a;
        logic [W2-1:0] op_b;
        logic [W2-1:0] op_c;
        logic [W2-1:0] maj;
        op_a      = {2'b00, a};
        op_b      = ~{2'b00, b};
        op_c      = ~{2'b00, c};
        csa_sum   = op_a ^ op_b ^ op_c;
        maj       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        csa_carry = {maj[W2-2:0], 1'b1};
    end

    // Stage 1 register: carry-save pair plus carry-in, loaded on an input accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s1_cin   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_sum   <= csa_sum;
            s1_carry <= csa_carry;
            s1_cin   <= ~bin;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Kogge-Stone prefix resolution of the stage 1 pair. The carry-in is merged
    // into bit 0's generate so the prefix tree covers it without an extra column.
    always_comb begin
        logic [W2-1:0] gen;
        logic [W2-1:0] prop;
        logic [W2-1:0] grp_g;
        logic [W2-1:0] grp_p;
        gen      = s1_sum & s1_carry;
        prop     = s1_sum ^ s1_carry;
        grp_g    = gen;
        grp_p    = prop;
        grp_g[0] = gen[0] | (prop[0] & s1_cin);
        for (int d = 1; d < W2; d = d * 2) begin
            // Descending index order so each level reads the previous level's values.
            for (int i = W2 - 1; i >= d; i--) begin
                grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
                grp_p[i] = grp_p[i] & grp_p[i-d];
            end
        end
        res = prop ^ {grp_g[W2-2:0], s1_cin};
    end

    // Stage 2 output register: loads when stage 1 advances, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            neg       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            neg       <= res[W2-1];
`ifdef SUB3_SAT_EN
            diff      <= res[W2-1] ? '0 : res;
`else
            diff      <= res;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sub3_pipe.sv
// Self-checking bench for sub3_pipe: directed vectors with literal expectations,
// a mid-stream reset, a back-to-back burst, backpressure, then a randomized soak
// scored against an integer-arithmetic reference queue.
module tb_sub3_pipe;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  c = '0;
    logic          bin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W+1:0]  diff;
    logic          neg;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W+1:0] d;
        logic         n;
    } res_t;

    res_t expq[$];
    res_t exp_r;
    res_t held;
    logic held_v = 1'b0;

    always #5 clk = ~clk;

    sub3_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .neg       (neg)
    );

    function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic [W-1:0] fc, input logic fbin);
        int   v;
        res_t r;
        v   = int'(fa) - int'(fb) - int'(fc) - int'(fbin);
        r.n = (v < 0);
        r.d = v[W+1:0];
`ifdef SUB3_SAT_EN
        if (r.n) r.d = '0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push model results on accepts, compare on output handshakes,
    // and verify outputs stay frozen while stalled.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_diff_neg", {diff, neg}, held);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    exp_r = expq.pop_front();
                    chk("diff", diff, exp_r.d);
                    chk("neg", neg, exp_r.n);
                end
            end
            if (in_valid && in_ready) expq.push_back(model(a, b, c, bin));
            held_v = out_valid && !out_ready;
            held.d = diff;
            held.n = neg;
        end
    end

    task automatic drain(input int cycles);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic [W-1:0] tc, input logic tbin,
                            input logic [W+1:0] ed, input logic en, input string nm);
        int cyc;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ta; b = tb; c = tc; bin = tbin;
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, 2);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_neg"}, neg, en);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int run;
        int hs;
        logic [W+1:0] e_neg_big;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("por_out_valid", out_valid, 0);
        chk("por_diff", diff, 0);
        chk("por_neg", neg, 0);
        chk("por_in_ready", in_ready, 1);

        // Directed vectors with literal expectations
`ifdef SUB3_SAT_EN
        e_neg_big = 18'h00000;
`else
        e_neg_big = 18'h20001;
`endif
        send_dir(16'h1234, 16'h0034, 16'h0200, 1'b0, 18'h01000, 1'b0, "v1");
        drain(3);
        send_dir(16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, e_neg_big, 1'b1, "v2");
        drain(3);
        send_dir(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 18'h0FFFF, 1'b0, "v3");
        drain(3);
        send_dir(16'd5, 16'd2, 16'd3, 1'b0, 18'h00000, 1'b0, "v4");
        drain(3);

        // Reset with the pipeline full
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = W'($urandom); b = W'($urandom); c = W'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
        a = W'($urandom); b = W'($urandom); c = W'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_diff", diff, 0);
        chk("mrst_neg", neg, 0);
        chk("mrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_out", out_valid, 0);
        end

        // Back-to-back burst of 8
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1;
                    a = W'($urandom); b = W'($urandom); c = W'($urandom); bin = 1'($urandom);
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                run = 0;
                while (out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
                chk("burst_run", run, 8);
            end
        join
        drain(3);

        // Backpressure: two accepts then stall, then drain in order
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        repeat (4) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom); bin = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", acc, 2);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
        end
        chk("bp_drained", hs, 2);
        chk("bp_queue_empty", expq.size(), 0);

        // Randomized soak with random valid/ready and corner-heavy operands
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            case ($urandom_range(3))
                0: a = '0;
                1: a = '1;
                default: a = W'($urandom);
            endcase
            b   = ($urandom_range(3) == 0) ? '1 : W'($urandom);
            c   = ($urandom_range(3) == 0) ? '0 : W'($urandom);
            bin = 1'($urandom);
        end
        drain(6);
        chk("soak_queue_empty", expq.size(), 0);
        chk("soak_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub3_pipe.md
Name: sub3_pipe

Overview:
- Pipelined three-operand subtractor: computes D = a − b − c − Bin. It is the inverse-direction companion to the three-operand carry-save/prefix adder datapath.
- Two register stages:
  - Stage 1: operand inversion plus carry-save compression.
  - Stage 2: prefix carry propagation, sign extraction and output register.
- Valid/ready handshakes on both sides, so it drops into streaming arithmetic pipelines alongside the adder blocks.

Parameters:
- WIDTH, 16, operand width in bits; result width is WIDTH+2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active high
- in_valid  input  1  operand set a/b/c/bin is valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  first subtrahend, unsigned
- c  input  WIDTH  second subtrahend, unsigned
- bin  input  1  borrow-in, weight 1
- out_valid  output  1  diff/neg valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH+2  two's-complement result
- neg  output  1  result is negative (diff MSB before any saturation)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Arithmetic:
  - diff = a − b − c − bin, exact, in WIDTH+2-bit two's complement.
  - Range is [−(2·(2^WIDTH−1)+1), 2^WIDTH−1]; this always fits, so there is no overflow.
  - Required formulation: a + ~b + ~c + 2 − bin over WIDTH+2 bits, with b and c zero-extended before inversion. The inversions and the constant are folded into the carry-save stage.
- Stage 1 (S1) register:
  - Holds a carry-save pair (sum vector, carry vector), WIDTH+2 bits each, plus s1_valid.
  - Capture occurs when in_valid && in_ready.
- Stage 2 (S2) register:
  - Holds diff, neg and out_valid.
  - The prefix adder resolves the S1 pair combinationally; S2 captures when S1 advances.
- Latency: 2 cycles from the accepting edge to out_valid when out_ready stays high. Throughput is 1 result/cycle.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free, which is combinational from out_ready.
  - out_valid falls after the handshake if S1 holds no valid data.
  - When out_valid && !out_ready: diff, neg and out_valid hold stable, and S1 holds its contents.
  - Simultaneous accept at the input and drain at the output in the same cycle is legal; there are no bubbles.
- Reset, in any state and including mid-stream:
  - Next edge clears s1_valid and out_valid to 0, and diff and neg to 0.
  - Data in flight is discarded.
  - in_ready is 1 in the first cycle after reset.
- Inputs are sampled only on an accepting edge; changes while in_ready=0 are ignored.

Optional Feature:
- Macro SUB3_SAT_EN.
- Defined:
  - Stage 2 clamps negative results, so diff = 0 whenever the true result < 0.
  - neg still reports the true sign, so neg=1 with diff=0 flags underflow.
  - Non-negative results are unchanged.
- Undefined: diff is always the exact two's-complement result; no clamp logic is generated.

Test Plan:
- Reset with pipeline full (two accepted operand sets, out_ready=0), assert rst one cycle → out_valid=0, diff=0, neg=0, in_ready=1; no stale result appears afterwards.
- a=0x1234, b=0x0034, c=0x0200, bin=0, out_ready=1 → exactly 2 cycles later diff=0x01000, neg=0.
- a=0x0000, b=0xFFFF, c=0xFFFF, bin=1 → diff = −131071 = 18'h20001, neg=1. With SUB3_SAT_EN: diff=0, neg=1.
- a=0xFFFF, b=0, c=0, bin=0 → diff=0x0FFFF, neg=0. a=5, b=2, c=3, bin=0 → diff=0, neg=0.
- Back-to-back stream of 8 random sets with out_ready=1 → 8 consecutive out_valid cycles; results match a reference model in order.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 → in_ready drops after 2 accepts; diff holds stable. Release out_ready → results drain in order with none lost or duplicated.
